sa_result_drain: RTL
====================

# sa_result_drain

Host-side reader for the systolic array core's result port. Waits until every column of the core reports a buffered result, captures all ROWS results in one cycle, and returns them to the core with a single-cycle `outread` pulse. Then serializes the captured words, column 0 first, onto a single valid/ready stream toward the host or DMA. Sits directly between the core's `routport`/`rvalidport`/`outread` and the downstream result sink.

## Interface
- `ROWS`, default 8, array dimension; results per frame. Must be ≥ 2.
- `OUTWIDTH`, default 32, result word width.
- `IDXW` (localparam), `$clog2(ROWS)`, column index width.

- `clk`  in  1  clock
- `rstn`  in  1  reset; synchronous, active-low; clock `clk`
- `r_in`  in  `[OUTWIDTH-1:0]` × `[0:ROWS-1]`  per-column results from the core
- `rvalid_in`  in  `[0:ROWS-1]`  per-column result-valid from the core
- `outread`  out  1  one-cycle pulse: all buffered core results consumed
- `m_data`  out  `OUTWIDTH`  stream data
- `m_col`  out  `IDXW`  column index of the current beat
- `m_last`  out  1  high on the beat with `m_col == ROWS-1`
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready from the sink
- `busy`  out  1  high while not in IDLE
- `frames_out`  out  16  count of completed frames; wraps

## Operation
- FSM states: `DR_IDLE` and `DR_SEND`.
- **DR_IDLE**
  - Capture condition: `&rvalid_in`, i.e. all ROWS bits high.
  - On capture, load all `r_in[i]` into a local bank `cap[i]`, clear the index to 0, assert `outread` next cycle, and go to DR_SEND.
  - A partial valid vector (some bits set, not all) causes no action; the block keeps waiting.
- **DR_SEND**
  - `m_valid` = 1, `m_data` = `cap[idx]`, `m_col` = `idx`, `m_last` = (`idx == ROWS-1`).
  - A beat is accepted on `m_valid && m_ready`; acceptance increments `idx`.
  - When the beat with `m_last` is accepted, go to DR_IDLE and increment `frames_out` (mod 2^16).
  - `rvalid_in` and `r_in` are ignored in DR_SEND. The core may refill its buffers during DR_SEND.
- **Core contract:** the core deasserts its `rvalidport` bits no later than the cycle after `outread`. Because ROWS ≥ 2 beats are sent, DR_IDLE never re-samples a stale frame.
- **Stream rule:** while `m_valid && !m_ready`, `m_data`, `m_col` and `m_last` hold stable. `m_valid` never drops before acceptance.
- **Reset mid-frame:** discards captured data and emits no `outread` and no further beats. The core shares `rstn` and clears with this block.

## Timing
- **Reset values:** `outread`=0, `m_valid`=0, `m_last`=0, `m_col`=0, `m_data`=0, `busy`=0, `frames_out`=0, state DR_IDLE.
- **Capture:** capture at cycle T (DR_IDLE and `&rvalid_in`). At T+1: `outread`=1 for exactly one cycle, `m_valid`=1, `m_col`=0, `busy`=1.
- **Latency:** first beat is offered 1 cycle after capture. With `m_ready` held high, beat k is accepted at T+1+k.
- **End of frame:** last beat accepted at cycle L. At L+1: DR_IDLE, `m_valid`=0, `busy`=0, `frames_out` incremented.
- **Back-to-back:** if `&rvalid_in` at L+1, the next capture happens at L+1. Minimum frame period is ROWS+1 cycles.
- All outputs are registered; there is no combinational path from `m_ready` to `m_valid`, `m_data` or `m_col`.

## Structure
- Shared package `sa_pkg`:
  - `drain_state_t` enum `{DR_IDLE, DR_SEND}`.
  - `FRAME_CNT_W` = 16.
- One module only. The capture bank is an array register inside `sa_result_drain`; no sub-module is warranted.

## Test plan
- **Single frame:** ROWS=8; `rvalid_in`=8'hFF, `r_in[i]`=100+i; `m_ready`=1.
  - One `outread` pulse at T+1.
  - Beats 100..107 with `m_col` 0..7 on T+1..T+8, `m_last` only on 107.
  - `frames_out`=1 at T+9.
- **Partial valid:** `rvalid_in`=8'hF7 held for 20 cycles, then 8'hFF.
  - No `outread` and no beats during the 20 cycles.
  - Capture on the first cycle of 8'hFF.
- **Backpressure:** `m_ready` toggles 1,0,0,1,… through a frame.
  - `m_data`/`m_col` stable during stalls.
  - All 8 beats in order, no duplicates or drops.
  - `outread` is still a single pulse at T+1.
- **Overlap and back-to-back:** `r_in` changes to 200+i during DR_SEND.
  - Frame 1 beats remain 100+i.
  - With `rvalid_in` re-high at L+1, frame 2 starts at L+2 with data 200+i.
- **Reset mid-frame:** assert `rstn`=0 after beat 3 is accepted.
  - Next cycle: `m_valid`=0, `busy`=0, `frames_out`=0.
  - After release, no residual beats appear.
- **Wrap:** preload by running 65536 frames (or force the counter to 16'hFFFF); `frames_out` goes 16'hFFFF→0.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic array host-side blocks.
package sa_pkg;

    typedef enum logic {
        DR_IDLE = 1'b0,
        DR_SEND = 1'b1
    } drain_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/sa_result_drain.sv
// Captures one full frame of column results from the core, acknowledges it with
// a single outread pulse, then streams the words (column 0 first) over valid/ready.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int  ROWS     = 8,
    parameter int  OUTWIDTH = 32,
    localparam int IDXW     = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [OUTWIDTH-1:0]    r_in [0:ROWS-1],
    input  logic [ROWS-1:0]        rvalid_in,
    output logic                   outread,
    output logic [OUTWIDTH-1:0]    m_data,
    output logic [IDXW-1:0]        m_col,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frames_out
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROWS - 1);

    drain_state_t          state, state_nxt;
    logic [OUTWIDTH-1:0]   cap [0:ROWS-1];
    logic                  capture, accept, last_accept;
    logic [IDXW-1:0]       idx_nxt;

    // m_col doubles as the beat index into the capture bank.
    assign idx_nxt = m_col + IDXW'(1);

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        case (state)
            DR_IDLE: begin
                if (&rvalid_in) begin
                    capture   = 1'b1;
                    state_nxt = DR_SEND;
                end
            end
            DR_SEND: begin
                if (m_valid && m_ready) begin
                    accept = 1'b1;
                    if (m_last) begin
                        last_accept = 1'b1;
                        state_nxt   = DR_IDLE;
                    end
                end
            end
            default: state_nxt = DR_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= DR_IDLE;
            outread    <= 1'b0;
            m_data     <= '0;
            m_col      <= '0;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            frames_out <= '0;
        end else begin
            state   <= state_nxt;
            outread <= capture;
            if (capture) begin
                m_data  <= r_in[0];
                m_col   <= '0;
                m_last  <= 1'b0;
                m_valid <= 1'b1;
                busy    <= 1'b1;
            end else if (last_accept) begin
                m_last     <= 1'b0;
                m_valid    <= 1'b0;
                busy       <= 1'b0;
                frames_out <= frames_out + FRAME_CNT_W'(1);
            end else if (accept) begin
                m_data <= cap[idx_nxt];
                m_col  <= idx_nxt;
                m_last <= (idx_nxt == LAST_IDX);
            end
        end
    end

    // NOTE: the capture bank is storage, not control; it is only read after a
    // capture has written it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < ROWS; i++) begin
                cap[i] <= r_in[i];
            end
        end
    end

endmodule
